// File: rtl/hls_mul_pipe_sat.sv
// Pipelined integer multiplier with per-operand signedness, optional round/shift/saturate,
// and a valid/ready handshake. All stages advance together; ce freezes everything.
module hls_mul_pipe_sat #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int SHIFT      = 0,
  parameter int ROUND_EN   = 0,
  parameter int SAT_EN     = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  sat_flag
);

  localparam int P      = din0_WIDTH + din1_WIDTH;
  // Working width leaves headroom for the rounding carry and for dout wider than the product.
  localparam int EW     = P + dout_WIDTH + 2;
  localparam bit RS     = (SIGNED0 != 0) || (SIGNED1 != 0);
  localparam int RK     = (NUM_STAGE >= 2) ? 2 : 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [EW-1:0] ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] RND  = (ROUND_EN != 0 && SHIFT > 0) ? (ONE <<< RND_SH) : '0;
  localparam logic signed [EW-1:0] MAXV = RS ? ((ONE <<< (dout_WIDTH-1)) - ONE)
                                             : ((ONE <<< dout_WIDTH) - ONE);
  localparam logic signed [EW-1:0] MINV = RS ? -(ONE <<< (dout_WIDTH-1)) : '0;

  logic                       adv;
  logic [NUM_STAGE:0]         vld_pipe;
  logic [NUM_STAGE:1]         vld_pipe_q, vld_pipe_d;
  logic [din0_WIDTH-1:0]      op0;
  logic [din1_WIDTH-1:0]      op1;
  logic signed [EW-1:0]       op0_x, op1_x, prod, shr;
  logic [dout_WIDTH:0]        res_calc;
  logic [NUM_STAGE:RK][dout_WIDTH:0] res_q, res_d;

  assign vld_pipe  = {vld_pipe_q, in_valid};
  assign out_valid = vld_pipe[NUM_STAGE];
  assign adv       = ce && (!out_valid || out_ready);
  assign in_ready  = adv;

  // With two or more stages the operands get their own register ahead of the math.
  generate
    if (NUM_STAGE >= 2) begin : g_opreg
      logic [din0_WIDTH-1:0] op0_q, op0_d;
      logic [din1_WIDTH-1:0] op1_q, op1_d;

      always_comb begin
        op0_d = op0_q;
        op1_d = op1_q;
        if (adv && in_valid) begin
          op0_d = din0;
          op1_d = din1;
        end
      end

      always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
          op0_q <= '0;
          op1_q <= '0;
        end else begin
          op0_q <= op0_d;
          op1_q <= op1_d;
        end
      end

      assign op0 = op0_q;
      assign op1 = op1_q;
    end else begin : g_comb
      assign op0 = din0;
      assign op1 = din1;
    end
  endgenerate

  // Unsigned results are never negative here, so one arithmetic shift serves both cases.
  always_comb begin
    op0_x = (SIGNED0 != 0) ? {{(EW-din0_WIDTH){op0[din0_WIDTH-1]}}, op0}
                           : {{(EW-din0_WIDTH){1'b0}}, op0};
    op1_x = (SIGNED1 != 0) ? {{(EW-din1_WIDTH){op1[din1_WIDTH-1]}}, op1}
                           : {{(EW-din1_WIDTH){1'b0}}, op1};
    prod  = op0_x * op1_x;
    shr   = (prod + RND) >>> SHIFT;
    res_calc = {1'b0, shr[dout_WIDTH-1:0]};
    if (SAT_EN != 0) begin
      if (shr > MAXV)      res_calc = {1'b1, MAXV[dout_WIDTH-1:0]};
      else if (shr < MINV) res_calc = {1'b1, MINV[dout_WIDTH-1:0]};
    end
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    res_d      = res_q;
    if (adv) begin
      vld_pipe_d = vld_pipe[NUM_STAGE-1:0];
      res_d[RK]  = res_calc;
      for (int s = RK + 1; s <= NUM_STAGE; s++) res_d[s] = res_q[s-1];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld_pipe_q <= '0;
      res_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      res_q      <= res_d;
    end
  end

  assign dout     = res_q[NUM_STAGE][dout_WIDTH-1:0];
  assign sat_flag = res_q[NUM_STAGE][dout_WIDTH];

endmodule

// File: tb/tb_hls_mul_pipe_sat.sv
// Drives several parameterisations in lockstep and scores each against an arithmetic model.
module tb_hls_mul_pipe_sat;

  localparam int NCFG = 8;
  localparam int NS_T  [NCFG] = '{3, 3, 3, 3, 3, 3, 1, 3};
  localparam int W_T   [NCFG] = '{26, 26, 26, 16, 16, 26, 26, 20};
  localparam int S0_T  [NCFG] = '{1, 1, 1, 1, 1, 0, 1, 0};
  localparam int S1_T  [NCFG] = '{1, 1, 1, 1, 1, 1, 1, 0};
  localparam int SH_T  [NCFG] = '{0, 4, 4, 0, 0, 0, 0, 3};
  localparam int RN_T  [NCFG] = '{0, 1, 0, 0, 0, 0, 0, 1};
  localparam int SAT_T [NCFG] = '{0, 0, 0, 1, 0, 0, 0, 1};

  typedef struct {
    logic [25:0] d;
    bit          s;
    longint      acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, ce, in_valid, out_ready;
  logic [13:0] din0;
  logic [11:0] din1;
  logic [NCFG-1:0] in_ready_w, out_valid_w;
  logic [25:0] dout0;
  bit          end_chk = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [13:0] a, input logic [11:0] b,
                                input int s0, input int s1, input int w, input int sh,
                                input int rnd, input int sat, output longint val, output bit sf);
    longint av, bv, r, mx, mn;
    av = longint'(a); if (s0 != 0 && a[13]) av -= 16384;
    bv = longint'(b); if (s1 != 0 && b[11]) bv -= 4096;
    r = av * bv;
    if (rnd != 0 && sh > 0) r += longint'(1) << (sh - 1);
    r = r >>> sh;
    mx = (s0 != 0 || s1 != 0) ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    mn = (s0 != 0 || s1 != 0) ? -(longint'(1) << (w - 1)) : 0;
    sf = 1'b0;
    val = r;
    if (sat != 0 && r > mx) begin val = mx; sf = 1'b1; end
    else if (sat != 0 && r < mn) begin val = mn; sf = 1'b1; end
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int NS = NS_T[g];
    localparam int W  = W_T[g];
    logic [W-1:0] d_loc;
    logic         ir, ov, sf;

    hls_mul_pipe_sat #(
      .ID(g), .NUM_STAGE(NS), .din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(W),
      .SIGNED0(S0_T[g]), .SIGNED1(S1_T[g]), .SHIFT(SH_T[g]), .ROUND_EN(RN_T[g]), .SAT_EN(SAT_T[g])
    ) u_dut (
      .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(ir),
      .din0(din0), .din1(din1), .out_valid(ov), .out_ready(out_ready),
      .dout(d_loc), .sat_flag(sf)
    );

    assign in_ready_w[g]  = ir;
    assign out_valid_w[g] = ov;

    exp_t         q[$];
    exp_t         e;
    bit           hold = 1'b0, rst_seen = 1'b0, ended = 1'b0, cons;
    logic [W-1:0] hd;
    bit           hs;
    longint       advc = 0;
    longint       mv;
    bit           msf;

    always @(negedge clk) begin
      chk(ir == (ce && (!ov || out_ready)), $sformatf("cfg%0d in_ready", g), ir, ce && (!ov || out_ready));
      if (rst_seen) begin
        chk(ov == 1'b0, $sformatf("cfg%0d reset out_valid", g), ov, 0);
        chk(d_loc == '0 && sf == 1'b0, $sformatf("cfg%0d reset dout", g), longint'(d_loc), 0);
      end
      if (!rst_n) begin
        q.delete();
        hold = 1'b0;
        rst_seen = 1'b1;
      end else begin
        rst_seen = 1'b0;
        if (hold)
          chk(ov && d_loc == hd && sf == hs, $sformatf("cfg%0d hold", g), longint'(d_loc), longint'(hd));
        cons = ov && out_ready && ce;
        if (cons) begin
          if (q.size() == 0) chk(1'b0, $sformatf("cfg%0d spurious output", g), longint'(d_loc), 0);
          else begin
            e = q.pop_front();
            chk(d_loc == e.d[W-1:0] && sf == e.s, $sformatf("cfg%0d data", g),
                longint'({sf, d_loc}), longint'({e.s, e.d[W-1:0]}));
            chk(advc - e.acc == NS, $sformatf("cfg%0d latency", g), advc - e.acc, NS);
          end
        end
        hold = ov && !cons;
        hd = d_loc;
        hs = sf;
        if (ce && (!ov || out_ready)) begin
          if (in_valid) begin
            model(din0, din1, S0_T[g], S1_T[g], W, SH_T[g], RN_T[g], SAT_T[g], mv, msf);
            e.d = mv[25:0];
            e.s = msf;
            e.acc = advc;
            q.push_back(e);
          end
          advc++;
        end
      end
      if (end_chk && !ended) begin
        ended = 1'b1;
        chk(q.size() == 0, $sformatf("cfg%0d drain", g), q.size(), 0);
      end
    end
  end

  assign dout0 = g_dut[0].d_loc;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [13:0] a, input logic [11:0] b);
    int t = 0;
    din0 = a; din1 = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_w[0] && t < 100) begin t++; @(negedge clk); end
    if (!in_ready_w[0]) chk(1'b0, "send timeout", t, 100);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint v;
    bit     s;
    // Hand-computed values pin the model itself.
    model(14'h2000, 12'h800, 1, 1, 26, 0, 0, 0, v, s); chk(v == 16777216 && !s, "pin default", v, 16777216);
    model(14'd5, 12'd8, 1, 1, 26, 4, 1, 0, v, s);      chk(v == 3, "pin round pos", v, 3);
    model(14'h3FFB, 12'd8, 1, 1, 26, 4, 1, 0, v, s);   chk(v == -2, "pin round neg", v, -2);
    model(14'd5, 12'd8, 1, 1, 26, 4, 0, 0, v, s);      chk(v == 2, "pin trunc pos", v, 2);
    model(14'h3FFB, 12'd8, 1, 1, 26, 4, 0, 0, v, s);   chk(v == -3, "pin trunc neg", v, -3);
    model(14'd8191, 12'd2047, 1, 1, 16, 0, 0, 1, v, s); chk(v == 32767 && s, "pin sat hi", v, 32767);
    model(14'h2000, 12'd2047, 1, 1, 16, 0, 0, 1, v, s); chk(v == -32768 && s, "pin sat lo", v, -32768);
    model(14'd100, 12'd100, 1, 1, 16, 0, 0, 1, v, s);  chk(v == 10000 && !s, "pin sat none", v, 10000);
    model(14'd8191, 12'd2047, 1, 1, 16, 0, 0, 0, v, s); chk((v & 64'hFFFF) == 64'hD801, "pin wrap", v & 64'hFFFF, 64'hD801);
    model(14'h3FFF, 12'hFFF, 0, 1, 26, 0, 0, 0, v, s); chk(v == -16383, "pin mixed sign", v, -16383);

    rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single beat on the default instance: valid exactly three cycles after accept.
    send(14'h2000, 12'h800);
    @(negedge clk); chk(out_valid_w[0] == 1'b0, "lat3 early1", out_valid_w[0], 0);
    @(negedge clk); chk(out_valid_w[0] == 1'b0, "lat3 early2", out_valid_w[0], 0);
    @(negedge clk); chk(out_valid_w[0] == 1'b1, "lat3 valid", out_valid_w[0], 1);
    chk(dout0 == 26'd16777216, "lat3 dout", dout0, 16777216);
    idle(4);

    send(14'd5, 12'd8); send(14'h3FFB, 12'd8); send(14'd8191, 12'd2047);
    send(14'h2000, 12'd2047); send(14'd100, 12'd100); send(14'h3FFF, 12'hFFF);
    idle(6);

    // Back-pressure: consumer stalls four cycles once results start arriving.
    fork
      for (int a = 1; a <= 5; a++) send(14'(a), 12'd3);
      begin
        int t = 0;
        while (!out_valid_w[0] && t < 50) begin @(posedge clk); #1; t++; end
        if (!out_valid_w[0]) chk(1'b0, "bp wait", t, 50);
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(8);

    // Clock-enable pause mid-stream.
    send(14'd77, 12'd13);
    ce = 1'b0; idle(2); ce = 1'b1;
    send(14'h3ABC, 12'h123); send(14'd9, 12'hFFE);
    idle(8);

    // Reset with beats in flight: none of them may come out.
    send(14'd11, 12'd1); send(14'd12, 12'd1); send(14'd13, 12'd1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(8);

    for (int c = 0; c < 800; c++) begin
      ce        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: begin din0 = 14'h1FFF; din1 = 12'h7FF; end
        1: begin din0 = 14'h2000; din1 = 12'h800; end
        2: begin din0 = 14'h3FFF; din1 = 12'hFFF; end
        default: begin din0 = 14'($urandom); din1 = 12'($urandom); end
      endcase
      idle(1);
    end

    ce = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    idle(12);
    end_chk = 1'b1;
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hls_mul_pipe_sat.md
Name: hls_mul_pipe_sat

Overview:
- Parametrised, pipelined integer multiplier. Generalises the team's single-cycle combinational signed multiply cores.
- Adds configurable latency, per-operand signedness, a valid/ready handshake with a clock-enable, and optional right-shift, rounding and saturation on the product.
- Sits between HLS datapath stages wherever a multiply must be retimed or narrowed without losing flow control.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 3, register stages from input accept to output valid; must be >= 1.
- din0_WIDTH, 14, width of operand 0.
- din1_WIDTH, 12, width of operand 1.
- dout_WIDTH, 26, result width.
- SIGNED0, 1, 1 = din0 is two's complement, 0 = unsigned.
- SIGNED1, 1, 1 = din1 is two's complement, 0 = unsigned.
- SHIFT, 0, arithmetic right shift applied to the full product; 0 to P-1.
- ROUND_EN, 0, 1 = add 2^(SHIFT-1) before shifting; ignored when SHIFT = 0.
- SAT_EN, 0, 1 = clamp to the dout range; 0 = wrap (keep low bits).

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  synchronous reset, active-low.
- ce  in  1  clock enable; low freezes the entire pipeline.
- in_valid  in  1  din0/din1 are valid.
- in_ready  out  1  block accepts inputs this cycle.
- din0  in  din0_WIDTH  operand 0.
- din1  in  din1_WIDTH  operand 1.
- out_valid  out  1  dout/sat_flag are valid.
- out_ready  in  1  consumer accepts dout.
- dout  out  dout_WIDTH  processed product.
- sat_flag  out  1  this result was clamped; qualified by out_valid.

Behaviour:
- Widths and signedness:
  - P = din0_WIDTH + din1_WIDTH.
  - The result is signed if SIGNED0 or SIGNED1 is 1, otherwise unsigned.
  - Each operand is sign- or zero-extended to P bits per its SIGNEDx before the multiply; the full P-bit product is exact.
- Post-processing, in order:
  - r = product + (ROUND_EN && SHIFT>0 ? 2^(SHIFT-1) : 0), computed at P+1 bits with no overflow.
  - r = r >> SHIFT; arithmetic shift if the result is signed, logical otherwise. This gives round-half-up toward +inf.
  - If dout_WIDTH >= the width of r: sign- or zero-extend into dout.
  - Otherwise, with SAT_EN=1: clamp to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1] when signed, or [0, 2^dout_WIDTH-1] when unsigned, and set sat_flag=1 when clamped.
  - Otherwise, with SAT_EN=0: keep the low dout_WIDTH bits; sat_flag=0.
- Pipeline and handshake:
  - There is one valid bit per stage, with global advance: adv = ce && (!out_valid || out_ready).
  - in_ready = adv, combinational; it does not depend on in_valid.
  - An input is accepted when in_valid && in_ready.
  - On adv, every stage shifts one position; stage 1 valid <= in_valid.
  - When !adv, all data and valid bits hold.
  - Latency is exactly NUM_STAGE cycles from acceptance to out_valid with no stalls. Throughput is 1 per cycle.
  - A result is consumed when out_valid && out_ready && ce.
  - Ordering is preserved; no result is dropped or duplicated.
  - Bubbles (in_valid=0 while accepting) propagate as invalid stages; they are not collapsed.
  - dout and sat_flag are stable while out_valid=1 and not consumed.
  - Register distribution across stages is free, but dout and sat_flag must come directly from flops.
- ce low:
  - No state changes.
  - in_ready=0.
  - out_valid and dout hold; out_ready is ignored.
- Reset (ap_rst_n=0 at an edge):
  - All valid bits 0, dout 0, sat_flag 0.
  - in_ready follows its equation with out_valid=0, i.e. in_ready = ce.
  - Reset mid-stream discards all in-flight data; out_valid=0 from the cycle after the reset edge.
  - Reset overrides ce.

Test Plan:
- Defaults: din0=0x2000 (-8192), din1=0x800 (-2048), one beat -> out_valid exactly 3 cycles after accept; dout=16777216; sat_flag=0.
- Back-pressure: 5 consecutive beats a*b with a=1..5, b=3; out_ready=0 for 4 cycles after the first out_valid -> in_ready=0 while stalled; outputs 3,6,9,12,15 in order, no loss or duplication.
- SHIFT=4, ROUND_EN=1: 5*8 -> dout=3; -5*8 -> dout=-2. With ROUND_EN=0: 5*8 -> 2; -5*8 -> -3.
- dout_WIDTH=16, SAT_EN=1:
  - 8191*2047 -> dout=32767, sat_flag=1.
  - -8192*2047 -> dout=-32768, sat_flag=1.
  - 100*100 -> dout=10000, sat_flag=0.
  - With SAT_EN=0, 8191*2047 -> dout=0xD801.
- SIGNED0=0, SIGNED1=1: din0=0x3FFF (16383), din1=0xFFF (-1) -> dout=-16383.
- Control: ce low for 2 cycles mid-stream -> all outputs frozen, latency extended by 2. ap_rst_n low for one cycle with 3 beats in flight -> out_valid=0 from the next cycle, those beats never emitted. NUM_STAGE=1 -> latency 1.
